fpdiv: RTL and testbench

//   Iterative floating-point divider, responder side of the start/ready protocol used by fpu to drive
//   its multi-cycle units. Computes out = a / b using radix-2 restoring mantissa division and

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_round_rne.sv | 35 +++
 rtl/fpdiv.sv | 178 +++++++++++++++++
 tb/tb_fpdiv.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the fpu execution units (fpaddsub, fpmul, fpdiv).
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  typedef logic [2:0] fpdiv_state_e;
  localparam fpdiv_state_e ST_IDLE   = 3'd0;
  localparam fpdiv_state_e ST_UNPACK = 3'd1;
  localparam fpdiv_state_e ST_ITER   = 3'd2;
  localparam fpdiv_state_e ST_ROUND  = 3'd3;
  localparam fpdiv_state_e ST_DONE   = 3'd4;

  function automatic int unsigned fp_bias(input int unsigned exp_bit);
    return (32'd1 << (exp_bit - 1)) - 32'd1;
  endfunction

  function automatic logic [63:0] fp_qnan(input int unsigned exp_bit, input int unsigned man_bit);
    return (((64'd1 << exp_bit) - 64'd1) << man_bit) | (64'd1 << (man_bit - 1));
  endfunction

  function automatic logic [63:0] fp_exp_field(input logic [63:0] w, input int unsigned exp_bit,
                                               input int unsigned man_bit);
    return (w >> man_bit) & ((64'd1 << exp_bit) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_man_field(input logic [63:0] w, input int unsigned man_bit);
    return w & ((64'd1 << man_bit) - 64'd1);
  endfunction

  // Exponent field of zero is treated as zero regardless of mantissa (flush-to-zero).
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero);
    if (exp_zero)      return FP_ZERO;
    else if (!exp_ones) return FP_NORM;
    else if (man_zero) return FP_INF;
    else               return FP_NAN;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised fraction, with exponent carry and range detection.
module fp_round_rne #(
  parameter int EXP_BIT = 8,
  parameter int MAN_BIT = 23
) (
  input  logic                      [MAN_BIT-1:0] mant,
  input  logic                                    guard,
  input  logic                                    sticky,
  input  logic signed               [EXP_BIT+1:0] exp,
  output logic                      [MAN_BIT-1:0] mant_out,
  output logic                      [EXP_BIT-1:0] exp_out,
  output logic                                    inexact,
  output logic                                    ovf,
  output logic                                    unf
);

  localparam logic signed [EXP_BIT+1:0] EXP_MAX = {2'b00, {EXP_BIT{1'b1}}};

  logic               round_up;
  logic [MAN_BIT:0]   sum;
  logic signed [EXP_BIT+1:0] exp_adj;

  always_comb begin
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + {{MAN_BIT{1'b0}}, round_up};
    // A carry out of the fraction leaves it all-zero, so only the exponent moves.
    exp_adj  = exp + {{(EXP_BIT+1){1'b0}}, sum[MAN_BIT]};
    mant_out = sum[MAN_BIT-1:0];
    exp_out  = exp_adj[EXP_BIT-1:0];
    inexact  = guard | sticky;
    ovf      = exp_adj >= EXP_MAX;
    unf      = exp_adj <= 0;
  end

endmodule

// File: rtl/fpdiv.sv
// Iterative radix-2 restoring floating-point divider with RNE rounding; start/ready responder.
module fpdiv
  import fp_pkg::*;
#(
  parameter  int LOG_BIT = 5,
  parameter  int EXP_BIT = 8,
  localparam int N_BIT   = 1 << LOG_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             start,
  output logic [N_BIT-1:0] out,
  output logic             ready,
  output logic [4:0]       flags
);

  localparam int MAN_BIT = N_BIT - EXP_BIT - 1;
  localparam int Q       = MAN_BIT + 3;
  localparam int CNT_W   = $clog2(Q + 1);
  localparam int EW      = EXP_BIT + 2;
  localparam logic signed [EW-1:0]  BIAS_S = EW'(fp_bias(EXP_BIT));
  localparam logic [N_BIT-1:0]      QNAN   = N_BIT'(fp_qnan(EXP_BIT, MAN_BIT));

  fpdiv_state_e           state;
  logic [N_BIT-1:0]       a_r, b_r;
  logic [MAN_BIT+1:0]     rem;
  logic [MAN_BIT:0]       div;
  logic [Q-1:0]           q;
  logic signed [EW-1:0]   exp_q;
  logic [CNT_W-1:0]       cnt;

  logic [EXP_BIT-1:0]     ea, eb;
  logic [MAN_BIT-1:0]     ma, mb;
  fp_class_e              ca, cb;
  logic                   sign;
  logic                   spec_hit;
  logic [N_BIT-1:0]       spec_out;
  logic [4:0]             spec_flags;
  logic [N_BIT-1:0]       inf_word, zero_word;

  always_comb begin
    ea        = EXP_BIT'(fp_exp_field(64'(a_r), EXP_BIT, MAN_BIT));
    eb        = EXP_BIT'(fp_exp_field(64'(b_r), EXP_BIT, MAN_BIT));
    ma        = MAN_BIT'(fp_man_field(64'(a_r), MAN_BIT));
    mb        = MAN_BIT'(fp_man_field(64'(b_r), MAN_BIT));
    ca        = fp_classify(ea == '0, &ea, ma == '0);
    cb        = fp_classify(eb == '0, &eb, mb == '0);
    sign      = a_r[N_BIT-1] ^ b_r[N_BIT-1];
    inf_word  = {sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    zero_word = {sign, {(N_BIT-1){1'b0}}};
  end

  // Priority matters: inf/0 must yield inf without div_by_zero, so a=inf is tested before b=0.
  always_comb begin
    spec_hit   = 1'b1;
    spec_out   = zero_word;
    spec_flags = '0;
    if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_INF) ||
        (ca == FP_ZERO && cb == FP_ZERO)) begin
      spec_out   = QNAN;
      spec_flags = 5'b10000;
    end else if (ca == FP_INF) begin
      spec_out = inf_word;
    end else if (cb == FP_ZERO) begin
      spec_out   = inf_word;
      spec_flags = 5'b01000;
    end else if (ca == FP_ZERO || cb == FP_INF) begin
      spec_out = zero_word;
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic                   ge;
  logic [MAN_BIT+1:0]     diff;

  always_comb begin
    ge   = rem >= {1'b0, div};
    diff = rem - {1'b0, div};
  end

  // Quotient lies in (0.5, 2): pick the fraction window by its integer bit.
  logic                   norm;
  logic [MAN_BIT-1:0]     frac_sel, mant_rnd;
  logic                   guard, sticky, inexact, ovf, unf;
  logic signed [EW-1:0]   exp_pre;
  logic [EXP_BIT-1:0]     exp_rnd;
  logic [N_BIT-1:0]       norm_out;
  logic [4:0]             norm_flags;

  always_comb begin
    norm     = q[Q-1];
    frac_sel = norm ? q[Q-2:2] : q[Q-3:1];
    guard    = norm ? q[1] : q[0];
    sticky   = norm ? (q[0] | (|rem)) : (|rem);
    exp_pre  = norm ? exp_q : exp_q - EW'(1);
  end

  fp_round_rne #(.EXP_BIT(EXP_BIT), .MAN_BIT(MAN_BIT)) u_round (
    .mant     (frac_sel),
    .guard    (guard),
    .sticky   (sticky),
    .exp      (exp_pre),
    .mant_out (mant_rnd),
    .exp_out  (exp_rnd),
    .inexact  (inexact),
    .ovf      (ovf),
    .unf      (unf)
  );

  always_comb begin
    if (ovf) begin
      norm_out   = inf_word;
      norm_flags = 5'b00101;
    end else if (unf) begin
      norm_out   = zero_word;
      norm_flags = 5'b00011;
    end else begin
      norm_out   = {sign, exp_rnd, mant_rnd};
      norm_flags = {4'b0000, inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ready <= 1'b1;
      out   <= '0;
      flags <= '0;
      a_r   <= '0;
      b_r   <= '0;
      rem   <= '0;
      div   <= '0;
      q     <= '0;
      exp_q <= '0;
      cnt   <= '0;
    end else if (start) begin
      a_r   <= a;
      b_r   <= b;
      ready <= 1'b0;
      state <= ST_UNPACK;
    end else begin
      case (state)
        ST_UNPACK: begin
          if (spec_hit) begin
            out   <= spec_out;
            flags <= spec_flags;
            ready <= 1'b1;
            state <= ST_DONE;
          end else begin
            rem   <= {2'b01, ma};
            div   <= {1'b1, mb};
            exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
            q     <= '0;
            cnt   <= '0;
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          rem <= ge ? {diff[MAN_BIT:0], 1'b0} : {rem[MAN_BIT:0], 1'b0};
          q   <= {q[Q-2:0], ge};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(Q - 1)) state <= ST_ROUND;
        end
        ST_ROUND: begin
          out   <= norm_out;
          flags <= norm_flags;
          ready <= 1'b1;
          state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv.sv
// Directed-vector bench for fpdiv: results, flags, handshake latency, restart and async reset.
module tb_fpdiv;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        start;
  logic [31:0] out;
  logic        ready;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_out = '0;

  fpdiv #(.LOG_BIT(5), .EXP_BIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .start (start),
    .out   (out),
    .ready (ready),
    .flags (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Called at #1 after a rising edge; issues start so it is sampled on the next edge.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] want, input logic [4:0] want_f, input int want_lat);
    int n;
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, "_busy"}, 32'(ready), 32'd0);
    check_val({tag, "_hold"}, out, last_out);
    wait_ready(n);
    check_val({tag, "_lat"}, 32'(n), 32'(want_lat));
    check_val({tag, "_out"}, out, want);
    check_val({tag, "_flags"}, 32'(flags), 32'(want_f));
    last_out = want;
  endtask

  initial begin
    int n;
    int busy_bad;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #8;
    check_val("rst_ready", 32'(ready), 32'd1);
    check_val("rst_out", out, 32'h0);
    check_val("rst_flags", 32'(flags), 32'h0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
    run_op("onehalf_by_one", 32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000, 28);
    run_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    run_op("neg1_by_inf", 32'hBF800000, 32'h7F800000, 32'h80000000, 5'b00000, 1);
    run_op("inf_by_zero", 32'hFF800000, 32'h00000000, 32'hFF800000, 5'b00000, 1);
    run_op("nan_in", 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
    run_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28);
    run_op("underflow", 32'h00800000, 32'h40800000, 32'h00000000, 5'b00011, 28);
    run_op("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28);

    // Result must be held while idle.
    repeat (3) @(posedge clk);
    #1 check_val("done_hold", out, last_out);

    // Restart mid-operation: 6/2 then 1/3 sampled on the tenth edge after the first start.
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_bad = 0;
    for (int i = 1; i < 10; i++) begin
      if (ready) busy_bad++;
      @(posedge clk); #1;
    end
    if (ready) busy_bad++;
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("restart_busy", 32'(busy_bad), 32'd0);
    wait_ready(n);
    check_val("restart_lat", 32'(n), 32'd28);
    check_val("restart_out", out, 32'h3EAAAAAB);
    check_val("restart_flags", 32'(flags), 32'h01);
    last_out = 32'h3EAAAAAB;

    // Asynchronous reset in the middle of the iteration phase.
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_ready", 32'(ready), 32'd1);
    check_val("midrst_out", out, 32'h0);
    check_val("midrst_flags", 32'(flags), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    last_out = '0;
    run_op("post_reset", 32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000, 28);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
